// File: rtl/cpu_pkg.sv
// Shared processor-datapath definitions: address width, PC reset address and address type.
package cpu_pkg;
  localparam int ADDR_W   = 8;
  localparam int PC_RESET = 0;

  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/pc_parity_gen.sv
// Combinational even-parity generator (XOR-reduce) for a PC-sized word.
module pc_parity_gen
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = ADDR_W
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  parity
);
  assign parity = ^data;
endmodule

// File: rtl/program_counter.sv
// Program-counter register: loads pc_in on every rising edge, asynchronous active-high reset.
// Optional registered parity output pc_par when the macro PC_PARITY_EN is defined.
module program_counter
  import cpu_pkg::*;
#(
  parameter int          DATA_WIDTH  = ADDR_W,
  parameter int unsigned RESET_VALUE = PC_RESET
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pc_in,
  output logic [DATA_WIDTH-1:0] pc_out
`ifdef PC_PARITY_EN
  ,
  output logic                  pc_par
`endif
);
  // rst_n is active-high despite its name; it keeps the established port name.
  localparam logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(RESET_VALUE);

`ifdef PC_PARITY_EN
  localparam logic RESET_PAR = ^RESET_PC;

  logic par_next;

  pc_parity_gen #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data  (pc_in),
    .parity(par_next)
  );
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pc_out <= RESET_PC;
`ifdef PC_PARITY_EN
      pc_par <= RESET_PAR;
`endif
    end else begin
      pc_out <= pc_in;
`ifdef PC_PARITY_EN
      pc_par <= par_next;
`endif
    end
  end
endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: an 8-bit default instance and a 16-bit instance with
// reset value 16'h0100, directed cases followed by random loads and async resets.
module tb_program_counter;
  logic        clk;
  logic        rst;
  logic [7:0]  pc_in8;
  logic [7:0]  pc_out8;
  logic [15:0] pc_in16;
  logic [15:0] pc_out16;
`ifdef PC_PARITY_EN
  logic        par8;
  logic        par16;
`endif

  localparam logic [7:0]  RST8  = 8'h00;
  localparam logic [15:0] RST16 = 16'h0100;

  program_counter dut8 (
    .clk   (clk),
    .rst_n (rst),
    .pc_in (pc_in8),
    .pc_out(pc_out8)
`ifdef PC_PARITY_EN
    ,
    .pc_par(par8)
`endif
  );

  program_counter #(
    .DATA_WIDTH (16),
    .RESET_VALUE(16'h0100)
  ) dut16 (
    .clk   (clk),
    .rst_n (rst),
    .pc_in (pc_in16),
    .pc_out(pc_out16)
`ifdef PC_PARITY_EN
    ,
    .pc_par(par16)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  v8;
    logic [15:0] v16;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  // Reference model: the PC each instance should be showing right now.
  logic [7:0]  m8;
  logic [15:0] m16;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [15:0] b);
    exp_t e;
    e.v8  = a;
    e.v16 = b;
    exp_q.push_back(e);
  endtask

  task automatic chk_now(input string tag);
    chk({tag, "_pc8"}, {8'h00, pc_out8}, {8'h00, m8});
    chk({tag, "_pc16"}, pc_out16, m16);
`ifdef PC_PARITY_EN
    chk({tag, "_par8"}, {15'd0, par8}, {15'd0, ^m8});
    chk({tag, "_par16"}, {15'd0, par16}, {15'd0, ^m16});
`endif
  endtask

  // One clock cycle: drive at the falling edge, expect the value after the next rising edge.
  task automatic drive(input logic rst_v, input logic [7:0] a, input logic [15:0] b);
    @(negedge clk);
    rst     = rst_v;
    pc_in8  = a;
    pc_in16 = b;
    if (rst_v) begin
      m8  = RST8;
      m16 = RST16;
      push(RST8, RST16);
    end else begin
      push(a, b);
    end
    #1;
    chk_now(rst_v ? "reset_level" : "hold_before_edge");
    if (!rst_v) begin
      m8  = a;
      m16 = b;
    end
  endtask

  // Raise reset between edges; output must snap to the reset value without a clock.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    m8  = RST8;
    m16 = RST16;
    push(RST8, RST16);
    #1;
    chk_now("async_reset");
  endtask

  // Monitor: the DUT presents a new PC every rising edge; compare against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pc8", {8'h00, pc_out8}, {8'h00, e.v8});
        chk("pc16", pc_out16, e.v16);
`ifdef PC_PARITY_EN
        chk("par8", {15'd0, par8}, {15'd0, ^e.v8});
        chk("par16", {15'd0, par16}, {15'd0, ^e.v16});
`endif
        $display("txn t=%0t rst=%b pc8=%h pc16=%h", $time, rst, pc_out8, pc_out16);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin
    logic [7:0]  r8;
    logic [15:0] r16;
    int          sel;

    rst     = 1'b1;
    pc_in8  = 8'h00;
    pc_in16 = 16'h0000;
    m8      = RST8;
    m16     = RST16;
    push(RST8, RST16);
    #1;
    chk_now("reset_initial");

    // Release, single load, back-to-back loads including all-ones.
    drive(1'b0, 8'h05, 16'h1234);
    drive(1'b0, 8'h06, 16'hFFFF);
    drive(1'b0, 8'hFF, 16'h0000);
    async_reset();
    drive(1'b0, 8'hA5, 16'h8001);
    drive(1'b0, 8'h07, 16'h0007);
    drive(1'b0, 8'h05, 16'h0005);
    drive(1'b1, 8'h3C, 16'hBEEF);
    drive(1'b0, 8'h3C, 16'hBEEF);

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 15);
      r8  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      r16 = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      if (sel == 0) async_reset();
      else drive(sel == 1, r8, r16);
    end
    drive(1'b0, 8'h11, 16'h2222);

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drain", 16'(exp_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
